uart_case_pipe: RTL and testbench
=================================

# uart_case_pipe

Parametrised byte-stream processor between the UART receiver's byte strobe and the UART transmitter's valid/ready input. Each received byte is translated per a runtime-selectable case mode, optionally expanded (CR → CR LF), and buffered in a first-word-fall-through FIFO of configurable depth. Bytes that cannot be buffered are dropped and counted. Supersedes the fixed uppercase-only, fixed-depth converter.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 4.
- CNT_W, 8: drop-counter width.
- EXPAND_CR, 1: 1 = each CR byte (0x0D) is written as CR then LF (0x0A).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_mode  in  2  case mode: 0 passthrough, 1 upper, 2 lower, 3 swap.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; no backpressure to source.
- o_tx_data  out  8  head-of-FIFO byte.
- o_tx_valid  out  1  FIFO non-empty.
- i_tx_ready  in  1  transmitter accepts byte.
- o_level  out  $clog2(DEPTH)+1  entries currently held.
- o_full  out  1  level == DEPTH.
- o_drop_cnt  out  CNT_W  saturating count of dropped bytes.
- i_clr_cnt  in  1  synchronous clear of o_drop_cnt.

## Operation
- Translation is combinational on i_rx_data and uses i_mode sampled in the strobe cycle. Bytes already buffered are never re-translated.
  - upper: 0x61–0x7A → minus 0x20.
  - lower: 0x41–0x5A → plus 0x20.
  - swap: both rules.
  - All other byte values pass unchanged in every mode.
- Push: on i_rx_valid, write the translated byte if there is room. Room means level < DEPTH, or level == DEPTH with a pop in the same cycle.
- If there is no room, the byte is discarded and o_drop_cnt increments.
- CR expansion (EXPAND_CR=1):
  - Writing CR sets lf_pend.
  - In the next cycle, LF is written if there is room and lf_pend clears.
  - If there is no room, lf_pend is held and the LF is retried every cycle until it is written. It is never dropped.
- Collision while lf_pend is set: the pending LF has priority. An i_rx_valid arriving in the same cycle is dropped and counted.
- If the CR itself is dropped, no LF is generated.
- Pop: on o_tx_valid && i_tx_ready, the read pointer advances. o_tx_data/o_tx_valid are driven from registered FIFO state only.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Level is derived from pointers with one extra MSB, so full and empty are unambiguous.
- Drop counter saturates at 2^CNT_W−1. i_clr_cnt wins over an increment in the same cycle (result 0).
- Reset mid-operation flushes the FIFO, lf_pend and the counter. Any byte in flight is lost and not counted.

## Timing
- Reset values:
  - o_tx_valid=0, o_tx_data=0x00, o_level=0, o_full=0, o_drop_cnt=0, lf_pend=0.
  - FIFO memory contents are not reset.
- Latency, strobe to output: a byte strobed in cycle N is visible on o_tx_data with o_tx_valid=1 in cycle N+1. There is no same-cycle bypass when empty.
- Expansion latency: LF is written at the end of cycle N+1 at the earliest and is visible one cycle behind its CR.
- Occupancy status: o_level and o_full update in the cycle after the push/pop edge.
- Counter latency: o_drop_cnt updates in the cycle after the drop.
- Handshake: o_tx_valid, once high, stays high with o_tx_data stable until popped.
- Throughput: one push and one pop per cycle.

## Structure
- Package uart_case_pkg holds:
  - mode encodings MODE_PASS/UPPER/LOWER/SWAP;
  - ASCII constants CR, LF, 'a', 'z', 'A', 'Z';
  - the function case_xlate(byte, mode).
- Sub-module uart_sync_fifo (WIDTH, DEPTH): FWFT, push/pop, level, full, empty. It has no knowledge of UART or ASCII.
- Top level holds the translation, the lf_pend state, the push arbitration and the drop counter.

## Test plan
- Modes: send "aZ1" in each of modes 0–3 with i_tx_ready=1. Required outputs:
  - mode 0: "aZ1";
  - mode 1: "AZ1";
  - mode 2: "az1";
  - mode 3: "Az1".
  Change i_mode while bytes are buffered; buffered bytes must be unaffected.
- Fill and drop: DEPTH=16, i_tx_ready=0, 18 strobes.
  - o_full=1 with o_level=16; o_drop_cnt=2.
  - Then i_tx_ready=1: the first 16 bytes drain in order.
  - Assert i_clr_cnt together with a drop: o_drop_cnt=0.
- Full with simultaneous pop: at level 16, strobe a byte in the same cycle as a pop. Byte is accepted, level stays 16, o_drop_cnt unchanged.
- CR expansion:
  - Send 0x0D then 'x' two cycles later: output 0x0D, 0x0A, 'x'.
  - Send 0x0D with level 15: LF waits until a pop and is not dropped.
  - A strobe colliding with the pending LF is dropped and counted.
- Saturation: CNT_W=2, 5 drops → o_drop_cnt=3.
- Reset mid-stream: assert rst_n low with 5 entries buffered and lf_pend set. Required: o_tx_valid=0 and o_level=0 asynchronously; no LF is emitted after release.

Source files
------------

// File: rtl/uart_case_pkg.sv
// Shared definitions for the UART case-conversion pipe: mode encodings,
// ASCII constants and the byte translation function.
package uart_case_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_UPPER = 2'd1,
      MODE_LOWER = 2'd2,
      MODE_SWAP  = 2'd3
   } mode_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_LA = 8'h61;  // 'a'
   localparam logic [7:0] ASCII_LZ = 8'h7A;  // 'z'
   localparam logic [7:0] ASCII_UA = 8'h41;  // 'A'
   localparam logic [7:0] ASCII_UZ = 8'h5A;  // 'Z'

   function automatic logic [7:0] case_xlate(input logic [7:0] b, input mode_e mode);
      logic       is_lower;
      logic       is_upper;
      logic [7:0] r;
      is_lower = (b >= ASCII_LA) && (b <= ASCII_LZ);
      is_upper = (b >= ASCII_UA) && (b <= ASCII_UZ);
      r        = b;
      if (is_lower && ((mode == MODE_UPPER) || (mode == MODE_SWAP))) begin
         r = b - 8'h20;
      end else if (is_upper && ((mode == MODE_LOWER) || (mode == MODE_SWAP))) begin
         r = b + 8'h20;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO. Pointers carry one extra MSB so that
// full and empty are distinguished without a separate flag.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign level_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (level_o == (AW+1)'(DEPTH));

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Head is masked while empty so the output reads zero after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_case_pipe.sv
// Byte-stream processor between UART RX strobe and TX valid/ready: case
// translation, optional CR->CR LF expansion, FWFT buffering, drop counting.
module uart_case_pipe
   import uart_case_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNT_W     = 8,
   parameter bit          EXPAND_CR = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               i_mode,
   input  logic [7:0]               i_rx_data,
   input  logic                     i_rx_valid,
   output logic [7:0]               o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic [CNT_W-1:0]         o_drop_cnt,
   input  logic                     i_clr_cnt
);

   logic [7:0]       xlated;
   logic [7:0]       wdata;
   logic             push, pop, room, drop;
   logic             fifo_empty, fifo_full;
   logic             lf_pend_q, lf_pend_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   assign xlated = case_xlate(i_rx_data, mode_e'(i_mode));
   assign pop    = !fifo_empty && i_tx_ready;
   assign room   = !fifo_full || pop;

   // A pending LF owns the write port; any strobe in that cycle is discarded.
   always_comb begin
      push      = 1'b0;
      wdata     = xlated;
      lf_pend_d = lf_pend_q;
      drop      = 1'b0;
      if (lf_pend_q) begin
         if (room) begin
            push      = 1'b1;
            wdata     = ASCII_LF;
            lf_pend_d = 1'b0;
         end
         drop = i_rx_valid;
      end else if (i_rx_valid) begin
         if (room) begin
            push      = 1'b1;
            lf_pend_d = EXPAND_CR && (xlated == ASCII_CR);
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (i_clr_cnt) begin
         drop_cnt_d = '0;
      end else if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lf_pend_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         lf_pend_q  <= lf_pend_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (o_tx_data),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (o_level)
   );

   assign o_tx_valid = !fifo_empty;
   assign o_full     = fifo_full;
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_case_pipe.sv
// Directed bench for uart_case_pipe (DEPTH=16, CNT_W=2, EXPAND_CR=1).
module tb_uart_case_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_mode;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready;
   logic [4:0] o_level;
   logic       o_full;
   logic [1:0] o_drop_cnt;
   logic       i_clr_cnt;

   int vec = 0;
   int err = 0;

   logic [7:0] src [3]    = '{8'h61, 8'h5A, 8'h31};
   logic [7:0] exp_m [12] = '{8'h61, 8'h5A, 8'h31,
                              8'h41, 8'h5A, 8'h31,
                              8'h61, 8'h7A, 8'h31,
                              8'h41, 8'h7A, 8'h31};

   uart_case_pipe #(
      .DEPTH     (16),
      .CNT_W     (2),
      .EXPAND_CR (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_mode     (i_mode),
      .i_rx_data  (i_rx_data),
      .i_rx_valid (i_rx_valid),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_level    (o_level),
      .o_full     (o_full),
      .o_drop_cnt (o_drop_cnt),
      .i_clr_cnt  (i_clr_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic clr();
      i_clr_cnt = 1'b1;
      tick();
      i_clr_cnt = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      vec++; if (o_tx_valid !== 1'b0) begin err++; $display("FAIL rst_valid act=%b exp=0", o_tx_valid); end
      vec++; if (o_tx_data !== 8'h00) begin err++; $display("FAIL rst_data act=%h exp=00", o_tx_data); end
      vec++; if (o_level !== 5'd0) begin err++; $display("FAIL rst_level act=%0d exp=0", o_level); end
      vec++; if (o_full !== 1'b0) begin err++; $display("FAIL rst_full act=%b exp=0", o_full); end
      vec++; if (o_drop_cnt !== 2'd0) begin err++; $display("FAIL rst_drop act=%0d exp=0", o_drop_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_modes();
      i_tx_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         i_mode = 2'(m);
         for (int k = 0; k < 3; k++) begin
            send(src[k]);
            vec++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_m[m*3+k])
               begin err++; $display("FAIL mode%0d_byte%0d act=%b/%h exp=1/%h", m, k, o_tx_valid, o_tx_data, exp_m[m*3+k]); end
         end
         tick();
         vec++; if (o_tx_valid !== 1'b0) begin err++; $display("FAIL mode%0d_empty act=%b exp=0", m, o_tx_valid); end
      end
      // buffered bytes must not follow later mode changes
      i_tx_ready = 1'b0;
      i_mode = 2'd1;
      for (int k = 0; k < 3; k++) send(src[k]);
      i_mode = 2'd2;
      tick();
      i_mode = 2'd3;
      i_tx_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vec++; if (o_tx_data !== exp_m[3+k]) begin err++; $display("FAIL mode_hold%0d act=%h exp=%h", k, o_tx_data, exp_m[3+k]); end
         tick();
      end
      i_tx_ready = 1'b0;
      i_mode = 2'd0;
   endtask

   task automatic test_fill_drop();
      clr();
      for (int i = 0; i < 18; i++) send(8'(8'h30 + i));
      vec++; if (o_level !== 5'd16) begin err++; $display("FAIL fill_level act=%0d exp=16", o_level); end
      vec++; if (o_full !== 1'b1) begin err++; $display("FAIL fill_full act=%b exp=1", o_full); end
      vec++; if (o_drop_cnt !== 2'd2) begin err++; $display("FAIL fill_drop act=%0d exp=2", o_drop_cnt); end
      i_rx_data = 8'hEE; i_rx_valid = 1'b1; i_clr_cnt = 1'b1;
      tick();
      i_rx_valid = 1'b0; i_clr_cnt = 1'b0;
      vec++; if (o_drop_cnt !== 2'd0) begin err++; $display("FAIL clr_vs_drop act=%0d exp=0", o_drop_cnt); end
      vec++; if (o_level !== 5'd16) begin err++; $display("FAIL clr_level act=%0d exp=16", o_level); end
   endtask

   task automatic test_full_pop();
      vec++; if (o_tx_data !== 8'h30) begin err++; $display("FAIL fp_head act=%h exp=30", o_tx_data); end
      i_rx_data = 8'h55; i_rx_valid = 1'b1; i_tx_ready = 1'b1;
      tick();
      i_rx_valid = 1'b0; i_tx_ready = 1'b0;
      vec++; if (o_level !== 5'd16) begin err++; $display("FAIL fp_level act=%0d exp=16", o_level); end
      vec++; if (o_drop_cnt !== 2'd0) begin err++; $display("FAIL fp_drop act=%0d exp=0", o_drop_cnt); end
      vec++; if (o_tx_data !== 8'h31) begin err++; $display("FAIL fp_next act=%h exp=31", o_tx_data); end
      i_tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 15) ? 8'(8'h31 + i) : 8'h55;
         vec++; if (o_tx_valid !== 1'b1 || o_tx_data !== e)
            begin err++; $display("FAIL drain%0d act=%b/%h exp=1/%h", i, o_tx_valid, o_tx_data, e); end
         tick();
      end
      i_tx_ready = 1'b0;
      vec++; if (o_tx_valid !== 1'b0 || o_level !== 5'd0)
         begin err++; $display("FAIL drain_empty act=%b/%0d exp=0/0", o_tx_valid, o_level); end
   endtask

   task automatic test_cr();
      logic [7:0] e3 [3] = '{8'h0D, 8'h0A, 8'h78};
      clr();
      send(8'h0D);
      vec++; if (o_tx_data !== 8'h0D || o_level !== 5'd1)
         begin err++; $display("FAIL cr_first act=%h/%0d exp=0d/1", o_tx_data, o_level); end
      tick();
      vec++; if (o_level !== 5'd2) begin err++; $display("FAIL cr_lf_lat act=%0d exp=2", o_level); end
      send(8'h78);
      vec++; if (o_level !== 5'd3) begin err++; $display("FAIL cr_x_level act=%0d exp=3", o_level); end
      i_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vec++; if (o_tx_data !== e3[i]) begin err++; $display("FAIL cr_seq%0d act=%h exp=%h", i, o_tx_data, e3[i]); end
         tick();
      end
      i_tx_ready = 1'b0;
      // strobe lands on the LF cycle
      send(8'h0D);
      send(8'h79);
      vec++; if (o_level !== 5'd2 || o_drop_cnt !== 2'd1)
         begin err++; $display("FAIL cr_collide act=%0d/%0d exp=2/1", o_level, o_drop_cnt); end
      i_tx_ready = 1'b1;
      vec++; if (o_tx_data !== 8'h0D) begin err++; $display("FAIL col_seq0 act=%h exp=0d", o_tx_data); end
      tick();
      vec++; if (o_tx_data !== 8'h0A) begin err++; $display("FAIL col_seq1 act=%h exp=0a", o_tx_data); end
      tick();
      i_tx_ready = 1'b0;
      vec++; if (o_tx_valid !== 1'b0) begin err++; $display("FAIL col_empty act=%b exp=0", o_tx_valid); end
   endtask

   task automatic test_cr_full();
      clr();
      for (int i = 0; i < 15; i++) send(8'(8'h20 + i));
      send(8'h0D);
      vec++; if (o_level !== 5'd16 || o_full !== 1'b1)
         begin err++; $display("FAIL crf_level act=%0d/%b exp=16/1", o_level, o_full); end
      repeat (3) tick();
      vec++; if (o_drop_cnt !== 2'd0) begin err++; $display("FAIL crf_lf_kept act=%0d exp=0", o_drop_cnt); end
      send(8'h77);
      vec++; if (o_drop_cnt !== 2'd1 || o_level !== 5'd16)
         begin err++; $display("FAIL crf_collide act=%0d/%0d exp=1/16", o_drop_cnt, o_level); end
      i_tx_ready = 1'b1;
      tick();
      i_tx_ready = 1'b0;
      vec++; if (o_level !== 5'd16 || o_drop_cnt !== 2'd1)
         begin err++; $display("FAIL crf_lf_in act=%0d/%0d exp=16/1", o_level, o_drop_cnt); end
      i_tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 14) ? 8'(8'h21 + i) : ((i == 14) ? 8'h0D : 8'h0A);
         vec++; if (o_tx_data !== e) begin err++; $display("FAIL crf_seq%0d act=%h exp=%h", i, o_tx_data, e); end
         tick();
      end
      i_tx_ready = 1'b0;
      vec++; if (o_tx_valid !== 1'b0) begin err++; $display("FAIL crf_empty act=%b exp=0", o_tx_valid); end
   endtask

   task automatic test_sat();
      clr();
      for (int i = 0; i < 19; i++) send(8'(8'h30 + i));
      vec++; if (o_drop_cnt !== 2'd3) begin err++; $display("FAIL sat3 act=%0d exp=3", o_drop_cnt); end
      send(8'h40);
      send(8'h40);
      vec++; if (o_drop_cnt !== 2'd3) begin err++; $display("FAIL sat5 act=%0d exp=3", o_drop_cnt); end
      i_tx_ready = 1'b1;
      repeat (16) tick();
      i_tx_ready = 1'b0;
      vec++; if (o_level !== 5'd0) begin err++; $display("FAIL sat_drain act=%0d exp=0", o_level); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
      send(8'h0D);
      vec++; if (o_level !== 5'd5) begin err++; $display("FAIL rm_pre act=%0d exp=5", o_level); end
      #2 rst_n = 1'b0;
      #1;
      vec++; if (o_tx_valid !== 1'b0 || o_level !== 5'd0)
         begin err++; $display("FAIL rm_async act=%b/%0d exp=0/0", o_tx_valid, o_level); end
      vec++; if (o_drop_cnt !== 2'd0) begin err++; $display("FAIL rm_cnt act=%0d exp=0", o_drop_cnt); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      vec++; if (o_tx_valid !== 1'b0 || o_level !== 5'd0 || o_tx_data !== 8'h00)
         begin err++; $display("FAIL rm_no_lf act=%b/%0d/%h exp=0/0/00", o_tx_valid, o_level, o_tx_data); end
   endtask

   initial begin
      i_mode = 2'd0; i_rx_data = 8'h00; i_rx_valid = 1'b0;
      i_tx_ready = 1'b0; i_clr_cnt = 1'b0;
      test_reset();
      test_modes();
      test_fill_drop();
      test_full_pop();
      test_cr();
      test_cr_full();
      test_sat();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
